// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - control and output bundle for the clock divider bank
interface clock_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*WIDTH-1:0] half_period;
  logic                    load;
  logic                    sync_clr;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;

  modport master (
    output en, half_period, load, sync_clr,
    input  clk_out, tick
  );

  modport slave (
    input  en, half_period, load, sync_clr,
    output clk_out, tick
  );
endinterface

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - multi-channel programmable divided clock and tick generator
module clock_divider_bank #(
  parameter int          NUM_CH       = 4,
  parameter int          WIDTH        = 32,
  parameter int unsigned DEFAULT_HALF = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clock_divider_bank_if.slave   bus
);

  logic [WIDTH-1:0]  div_q    [NUM_CH];
  logic [WIDTH-1:0]  div_d    [NUM_CH];
  logic [WIDTH-1:0]  cnt_q    [NUM_CH];
  logic [WIDTH-1:0]  cnt_d    [NUM_CH];
  logic [WIDTH-1:0]  last_cnt [NUM_CH];
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // Terminal count per channel: H-1, where a programmed half-period of 0 behaves as 1
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      last_cnt[i] = (div_q[i] == '0) ? '0 : div_q[i] - WIDTH'(1);
    end
  end

  // Next state per channel; sync_clr outranks load, which outranks counting
  always_comb begin
    clk_out_d = clk_out_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (bus.sync_clr) begin
        if (bus.load) begin
          div_d[i] = bus.half_period[i*WIDTH +: WIDTH];
        end
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
      end else if (bus.load) begin
        // clk_out keeps its level so a reprogram never produces a runt pulse
        div_d[i] = bus.half_period[i*WIDTH +: WIDTH];
        cnt_d[i] = '0;
      end else if (bus.en[i]) begin
        if (cnt_q[i] == last_cnt[i]) begin
          cnt_d[i]     = '0;
          clk_out_d[i] = ~clk_out_q[i];
          tick_d[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset reloads the default half-period into every channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= WIDTH'(DEFAULT_HALF);
        cnt_q[i] <= '0;
      end
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed self-checking bench for clock_divider_bank
module tb_clock_divider_bank;
  localparam int NCH = 4;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clock_divider_bank_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  clock_divider_bank #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_HALF(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*W-1:0] halves(input int h3, input int h2, input int h1, input int h0);
    return {W'(h3), W'(h2), W'(h1), W'(h0)};
  endfunction

  logic [3:0] ec, et;

  initial begin
    rst_n            = 1'b0;
    bus.en           = '0;
    bus.half_period  = '0;
    bus.load         = 1'b0;
    bus.sync_clr     = 1'b0;
    step();
    step();
    chk("rst_clk", 32'(bus.clk_out), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);

    // Default half-period of 8 after reset release
    bus.en = 4'hF;
    rst_n  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("dflt_clk", 32'(bus.clk_out), (k == 8) ? 32'hF : 32'h0);
      chk("dflt_tick", 32'(bus.tick), (k == 8) ? 32'hF : 32'h0);
    end

    // sync_clr + load together while clk_out is high: H = 3,0,1,5 on ch0..ch3
    bus.half_period = halves(5, 1, 0, 3);
    bus.load        = 1'b1;
    bus.sync_clr    = 1'b1;
    step();
    bus.load     = 1'b0;
    bus.sync_clr = 1'b0;
    chk("clrld_clk", 32'(bus.clk_out), 32'h0);
    chk("clrld_tick", 32'(bus.tick), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      step();
      ec = {1'((k / 5) % 2), 1'(k % 2), 1'(k % 2), 1'((k / 3) % 2)};
      et = {(k % 5) == 0, 1'b1, 1'b1, (k % 3) == 0};
      chk("run_clk", 32'(bus.clk_out), 32'(ec));
      chk("run_tick", 32'(bus.tick), 32'(et));
    end

    // H=4 on all, then freeze channel 0 at cnt=2
    bus.half_period = halves(4, 4, 4, 4);
    bus.load        = 1'b1;
    step();
    bus.load = 1'b0;
    chk("ld4_clk", 32'(bus.clk_out), 32'h0);
    chk("ld4_tick", 32'(bus.tick), 32'h0);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("h4_clk", 32'(bus.clk_out), (j >= 4) ? 32'hF : 32'h0);
      chk("h4_tick", 32'(bus.tick), (j == 4) ? 32'hF : 32'h0);
    end
    bus.en = 4'hE;
    for (int d = 1; d <= 7; d++) begin
      step();
      chk("en_off_clk0", 32'(bus.clk_out[0]), 32'h1);
      chk("en_off_tick0", 32'(bus.tick[0]), 32'h0);
    end
    bus.en = 4'hF;
    step();
    chk("resume1_clk0", 32'(bus.clk_out[0]), 32'h1);
    chk("resume1_tick0", 32'(bus.tick[0]), 32'h0);
    step();
    chk("resume2_clk0", 32'(bus.clk_out[0]), 32'h0);
    chk("resume2_tick0", 32'(bus.tick[0]), 32'h1);
    for (int r = 3; r <= 8; r++) begin
      step();
      chk("h4b_clk0", 32'(bus.clk_out[0]), (r >= 6) ? 32'h1 : 32'h0);
      chk("h4b_tick0", 32'(bus.tick[0]), (r == 6) ? 32'h1 : 32'h0);
    end

    // Reload H=6 at cnt=2 with clk_out[0]=1: level holds, toggles 6 edges later
    bus.half_period = halves(6, 6, 6, 6);
    bus.load        = 1'b1;
    step();
    bus.load = 1'b0;
    chk("ld6_clk0", 32'(bus.clk_out[0]), 32'h1);
    chk("ld6_tick0", 32'(bus.tick[0]), 32'h0);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("h6_clk0", 32'(bus.clk_out[0]), (j < 6 || j == 12) ? 32'h1 : 32'h0);
      chk("h6_tick0", 32'(bus.tick[0]), (j == 6 || j == 12) ? 32'h1 : 32'h0);
    end
    step();
    step();
    chk("pre_rst_clk0", 32'(bus.clk_out[0]), 32'h1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk", 32'(bus.clk_out), 32'h0);
    chk("arst_tick", 32'(bus.tick), 32'h0);
    step();
    chk("arst_hold_clk", 32'(bus.clk_out), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_rst_clk", 32'(bus.clk_out), (k == 8) ? 32'hF : 32'h0);
      chk("post_rst_tick", 32'(bus.tick), (k == 8) ? 32'hF : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parameterised multi-channel clock-enable/divided-clock generator; successor to the fixed four-output divider.
- Each of NUM_CH channels divides the system clock by a runtime-programmable half-period.
- Each channel produces a 50%-duty divided level (clk_out) and a one-cycle tick strobe.
- Feeds the display blink, adjust, count and scan logic; downstream logic uses tick as a clock enable rather than clk_out as a clock.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- WIDTH, 32, width of each half-period value and its counter.
- DEFAULT_HALF, 50000000, half-period loaded into every channel at reset; 1 Hz at 100 MHz.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NUM_CH  per-channel count enable.
- half_period  in  NUM_CH*WIDTH  packed new half-periods; channel i is bits [i*WIDTH +: WIDTH].
- load  in  1  one-cycle strobe that latches half_period into all channels.
- sync_clr  in  1  synchronous clear of all channel phase.
- clk_out  out  NUM_CH  divided clock levels.
- tick  out  NUM_CH  one-cycle pulse on each clk_out toggle.

Behaviour:
- Per-channel state:
  - div_q[i] (WIDTH bits): latched half-period.
  - cnt[i] (WIDTH bits).
  - clk_out[i], tick[i]: registered outputs.
- Reset (rst_n low, asynchronous, any time): cnt=0, clk_out=0, tick=0, div_q=DEFAULT_HALF for all channels. No output toggles while rst_n is low. Counting starts on the first rising clk edge after rst_n goes high.
- Effective half-period: H = div_q, except div_q=0 is treated as H=1.
- Counting, with en[i]=1 and no clr or load:
  - If cnt==H-1: cnt<=0, clk_out<=~clk_out, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Result: clk_out period is exactly 2H clk cycles at 50% duty. tick is high for exactly 1 cycle every H cycles and rises on the same edge as each clk_out transition.
  - H=1: clk_out toggles every cycle and tick is held continuously high.
- en[i]=0: cnt and clk_out hold, tick=0. When en returns high, counting resumes from the held cnt with no phase loss.
- load=1:
  - All channels: div_q<=half_period slice, cnt<=0, tick<=0. clk_out holds its level, so there is no glitch.
  - Applies regardless of en.
  - The first toggle after a load occurs H_new cycles after the load edge, if enabled.
- sync_clr=1: all channels cnt<=0, clk_out<=0, tick<=0. div_q is unchanged.
- Priority, per edge: rst_n > sync_clr > load > count.
  - sync_clr and load in the same cycle: div_q takes the new value and cnt, clk_out and tick all clear.
- Counter width: cnt compares only against H-1 < 2^WIDTH, so it never wraps. If div_q is reduced by load, cnt is cleared anyway, so cnt>H-1 cannot occur.
- Channels are independent apart from the shared load and sync_clr.
- Latency:
  - load or sync_clr takes effect on the edge where it is sampled.
  - tick and clk_out are registered, so there is no combinational path from inputs to outputs.
- All outputs are registered and glitch-free. clk_out must not drive clock pins; use tick as the enable.

Test Plan:
- Reset, en=all 1, channel 0 loaded with H=3 -> clk_out[0] toggles every 3 cycles (period 6, 3 high/3 low). tick[0] is 1 on each toggle edge and 0 otherwise.
- Load half_period ch1=0 and ch2=1 -> both toggle every cycle and both ticks stay high. Ch3 with H=5 -> period 10.
- H=4, drop en[0] for 7 cycles mid-count at cnt=2 -> clk_out and cnt frozen and tick=0 during the drop. The next toggle occurs 2 enabled cycles after en returns high.
- H=4 running, pulse load with H=6 when cnt=2 and clk_out=1 -> clk_out stays 1, then toggles exactly 6 cycles after the load edge. No tick during that window.
- Assert sync_clr and load together with clk_out=1 -> next edge clk_out=0, cnt=0, div_q=new value. Subsequent period equals 2×new H.
- Assert rst_n=0 asynchronously between edges mid-count -> clk_out and tick go 0 immediately. After release, div_q=DEFAULT_HALF, checked by overriding DEFAULT_HALF=8 so the first toggle comes 8 cycles after release.
